// File: rtl/llc_set_read.sv
// llc_set_read: reads one LLC set into per-way output buffers and keeps those
// buffers coherent with writes from llc_update while the read is in flight or held.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   rd_req_valid/set/ready   set-read request handshake
//   rd_en, rd_set            memory read strobe and address (combinational on accept)
//   mem_*                    per-way memory read data, valid the cycle after rd_en
//   upd_*                    single-way write snoop from llc_update
//   bufs_valid/ready         output handshake; *_buf, evict_way_buf, bufs_set hold the set
module llc_set_read #(
    localparam int LLC_WAYS    = 4,
    localparam int LLC_SET_W   = 8,
    localparam int LLC_WAY_W   = 2,
    localparam int LLC_TAG_W   = 12,
    localparam int LLC_STATE_W = 2,
    localparam int HPROT_W     = 1,
    localparam int SHARERS_W   = 4,
    localparam int OWNER_W     = 2,
    localparam int LINE_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_req_valid,
    input  logic [LLC_SET_W-1:0]   rd_req_set,
    output logic                   rd_req_ready,
    output logic                   rd_en,
    output logic [LLC_SET_W-1:0]   rd_set,
    input  logic [LLC_TAG_W-1:0]   mem_tags       [LLC_WAYS],
    input  logic [LLC_STATE_W-1:0] mem_states     [LLC_WAYS],
    input  logic [HPROT_W-1:0]     mem_hprots     [LLC_WAYS],
    input  logic                   mem_dirty_bits [LLC_WAYS],
    input  logic [SHARERS_W-1:0]   mem_sharers    [LLC_WAYS],
    input  logic [OWNER_W-1:0]     mem_owners     [LLC_WAYS],
    input  logic [LINE_W-1:0]      mem_lines      [LLC_WAYS],
    input  logic [LLC_WAY_W-1:0]   mem_evict_way,
    input  logic                   upd_wr_en,
    input  logic                   upd_wr_en_evict_way,
    input  logic [LLC_SET_W-1:0]   upd_set,
    input  logic [LLC_WAY_W-1:0]   upd_way,
    input  logic [LLC_TAG_W-1:0]   upd_data_tag,
    input  logic [LLC_STATE_W-1:0] upd_data_state,
    input  logic [HPROT_W-1:0]     upd_data_hprot,
    input  logic                   upd_data_dirty_bit,
    input  logic [SHARERS_W-1:0]   upd_data_sharers,
    input  logic [OWNER_W-1:0]     upd_data_owner,
    input  logic [LINE_W-1:0]      upd_data_line,
    input  logic [LLC_WAY_W-1:0]   upd_data_evict_way,
    output logic                   bufs_valid,
    input  logic                   bufs_ready,
    output logic [LLC_TAG_W-1:0]   tags_buf       [LLC_WAYS],
    output logic [LLC_STATE_W-1:0] states_buf     [LLC_WAYS],
    output logic [HPROT_W-1:0]     hprots_buf     [LLC_WAYS],
    output logic                   dirty_bits_buf [LLC_WAYS],
    output logic [SHARERS_W-1:0]   sharers_buf    [LLC_WAYS],
    output logic [OWNER_W-1:0]     owners_buf     [LLC_WAYS],
    output logic [LINE_W-1:0]      lines_buf      [LLC_WAYS],
    output logic [LLC_WAY_W-1:0]   evict_way_buf,
    output logic [LLC_SET_W-1:0]   bufs_set
);
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;
    state_t                 r_state, w_state_nxt;
    logic                   w_accept, w_live, w_upd_ev_hit;
    logic [LLC_WAYS-1:0]    w_upd_way, w_pend_way;
    logic                   r_pend_valid, r_pend_ev;
    logic [LLC_WAY_W-1:0]   r_pend_way, r_pend_evict_way;
    logic [LLC_TAG_W-1:0]   r_pend_tag;
    logic [LLC_STATE_W-1:0] r_pend_state;
    logic [HPROT_W-1:0]     r_pend_hprot;
    logic                   r_pend_dirty;
    logic [SHARERS_W-1:0]   r_pend_sharers;
    logic [OWNER_W-1:0]     r_pend_owner;
    logic [LINE_W-1:0]      r_pend_line;
    // Ready is masked while rst is high so nothing is accepted during reset.
    always_comb begin
        rd_req_ready = !rst && (r_state == IDLE || (r_state == HOLD && bufs_ready));
        w_accept     = rd_req_valid && rd_req_ready;
        rd_en        = w_accept;
        rd_set       = rd_req_set;
        bufs_valid   = r_state == HOLD;
        w_live       = r_state != IDLE;
        w_state_nxt  = w_accept ? WAIT :
                       r_state == WAIT ? HOLD :
                       (r_state == HOLD && bufs_ready) ? IDLE : r_state;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end
    // Writes that hit the set being read (WAIT) or held (HOLD); bufs_set already
    // holds that set from the accept cycle onward.
    always_comb begin
        w_upd_way    = '0;
        w_pend_way   = '0;
        w_upd_ev_hit = upd_wr_en_evict_way && upd_set == bufs_set;
        for (int w = 0; w < LLC_WAYS; w++) begin
            w_upd_way[w]  = upd_wr_en && upd_set == bufs_set && upd_way == LLC_WAY_W'(w);
            w_pend_way[w] = r_pend_valid && r_pend_way == LLC_WAY_W'(w);
        end
    end
    // A write in the accept cycle is missed by the read-first memory, so it is
    // parked here for exactly one cycle and replayed over mem_* in WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend_valid     <= 1'b0;
            r_pend_ev        <= 1'b0;
            r_pend_way       <= '0;
            r_pend_evict_way <= '0;
            r_pend_tag       <= '0;
            r_pend_state     <= '0;
            r_pend_hprot     <= '0;
            r_pend_dirty     <= 1'b0;
            r_pend_sharers   <= '0;
            r_pend_owner     <= '0;
            r_pend_line      <= '0;
        end else begin
            r_pend_valid     <= w_accept && upd_wr_en && upd_set == rd_req_set;
            r_pend_ev        <= w_accept && upd_wr_en_evict_way && upd_set == rd_req_set;
            r_pend_way       <= upd_way;
            r_pend_evict_way <= upd_data_evict_way;
            r_pend_tag       <= upd_data_tag;
            r_pend_state     <= upd_data_state;
            r_pend_hprot     <= upd_data_hprot;
            r_pend_dirty     <= upd_data_dirty_bit;
            r_pend_sharers   <= upd_data_sharers;
            r_pend_owner     <= upd_data_owner;
            r_pend_line      <= upd_data_line;
        end
    end
    // Priority per way: live write > pending write > memory data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bufs_set      <= '0;
            evict_way_buf <= '0;
            for (int w = 0; w < LLC_WAYS; w++) begin
                tags_buf[w]       <= '0;
                states_buf[w]     <= '0;
                hprots_buf[w]     <= '0;
                dirty_bits_buf[w] <= 1'b0;
                sharers_buf[w]    <= '0;
                owners_buf[w]     <= '0;
                lines_buf[w]      <= '0;
            end
        end else begin
            if (w_accept) bufs_set <= rd_req_set;
            for (int w = 0; w < LLC_WAYS; w++) begin
                if (w_live && w_upd_way[w]) begin
                    tags_buf[w]       <= upd_data_tag;
                    states_buf[w]     <= upd_data_state;
                    hprots_buf[w]     <= upd_data_hprot;
                    dirty_bits_buf[w] <= upd_data_dirty_bit;
                    sharers_buf[w]    <= upd_data_sharers;
                    owners_buf[w]     <= upd_data_owner;
                    lines_buf[w]      <= upd_data_line;
                end else if (r_state == WAIT && w_pend_way[w]) begin
                    tags_buf[w]       <= r_pend_tag;
                    states_buf[w]     <= r_pend_state;
                    hprots_buf[w]     <= r_pend_hprot;
                    dirty_bits_buf[w] <= r_pend_dirty;
                    sharers_buf[w]    <= r_pend_sharers;
                    owners_buf[w]     <= r_pend_owner;
                    lines_buf[w]      <= r_pend_line;
                end else if (r_state == WAIT) begin
                    tags_buf[w]       <= mem_tags[w];
                    states_buf[w]     <= mem_states[w];
                    hprots_buf[w]     <= mem_hprots[w];
                    dirty_bits_buf[w] <= mem_dirty_bits[w];
                    sharers_buf[w]    <= mem_sharers[w];
                    owners_buf[w]     <= mem_owners[w];
                    lines_buf[w]      <= mem_lines[w];
                end
            end
            if (w_live && w_upd_ev_hit) evict_way_buf <= upd_data_evict_way;
            else if (r_state == WAIT)   evict_way_buf <= r_pend_ev ? r_pend_evict_way : mem_evict_way;
        end
    end
endmodule
